alu_exec_unit: RTL and testbench

//  - Execution-side responder for the register-file controller.
//  - Accepts an opcode plus two operands on a start strobe and computes the result.
//  - Returns y and the O/C/Z/N flags that the controller consumes.
//  - Single-cycle ops finish in 1 cycle; the optional multiply is iterative.
//  - Sits between the controller's operand outputs and its y/flag inputs.

---
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_exec_unit.sv | 202 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between the register-file controller (master) and the
// execution unit (slave).
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_op_code;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             O;
  logic             C;
  logic             Z;
  logic             N;

  modport master (
    output start, alu_op_code, data_a, data_b,
    input  busy, done, y, O, C, Z, N
  );

  modport slave (
    input  start, alu_op_code, data_a, data_b,
    output busy, done, y, O, C, Z, N
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle ALU ops plus an optional iterative shift-add
// multiplier, enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b111;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam int         CW      = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  logic [2*WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             o_q, o_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic [WIDTH-1:0] b_opnd;
  logic             carry_in;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] ex_y;
  logic             ex_c;
  logic             ex_o;

  // Single-cycle datapath straight from the live operands; its result is
  // captured on the accepting edge, so later operand changes cannot leak in.
  always_comb begin
    b_opnd   = bus.data_b;
    carry_in = 1'b0;
    if (bus.alu_op_code == OP_SUB) begin
      b_opnd   = ~bus.data_b;
      carry_in = 1'b1;
    end
    sum_ext = {1'b0, bus.data_a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, carry_in};

    ex_y = '0;
    ex_c = 1'b0;
    ex_o = 1'b0;
    case (bus.alu_op_code)
      OP_ADD: begin
        ex_y = sum_ext[WIDTH-1:0];
        ex_c = sum_ext[WIDTH];
        ex_o = (bus.data_a[WIDTH-1] == bus.data_b[WIDTH-1]) &&
               (ex_y[WIDTH-1] != bus.data_a[WIDTH-1]);
      end
      OP_SUB: begin
        ex_y = sum_ext[WIDTH-1:0];
        ex_c = sum_ext[WIDTH];
        ex_o = (bus.data_a[WIDTH-1] != bus.data_b[WIDTH-1]) &&
               (ex_y[WIDTH-1] != bus.data_a[WIDTH-1]);
      end
      OP_AND:  ex_y = bus.data_a & bus.data_b;
      OP_OR:   ex_y = bus.data_a | bus.data_b;
      OP_XOR:  ex_y = bus.data_a ^ bus.data_b;
      OP_SLT:  ex_y = {{(WIDTH-1){1'b0}}, ($signed(bus.data_a) < $signed(bus.data_b))};
      OP_PASS: ex_y = bus.data_a;
      default: ex_y = '0;
    endcase
  end

  // busy stays high through the done cycle so a start coinciding with done
  // is ignored; after a multiply that cycle is spent in IDLE with busy set.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    o_d     = o_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
`ifdef ALU_EXEC_MUL_EN
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    acc_sum = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (bus.start) begin
`ifdef ALU_EXEC_MUL_EN
          if (bus.alu_op_code == OP_MUL) begin
            state_d = MUL;
            busy_d  = 1'b1;
            acc_d   = '0;
            a_sh_d  = {{WIDTH{1'b0}}, bus.data_a};
            b_sh_d  = bus.data_b;
            cnt_d   = CW'(WIDTH);
          end else
`endif
          begin
            state_d = EXEC;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            y_d     = ex_y;
            c_d     = ex_c;
            o_d     = ex_o;
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
`ifdef ALU_EXEC_MUL_EN
      MUL: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          y_d     = acc_sum[WIDTH-1:0];
          c_d     = |acc_sum[2*WIDTH-1:WIDTH];
          o_d     = |acc_sum[2*WIDTH-1:WIDTH];
        end
      end
`endif
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (done_d) begin
      z_d = (y_d == '0);
      n_d = y_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      o_q     <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      o_q     <= o_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
`ifdef ALU_EXEC_MUL_EN
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.O    = o_q;
  assign bus.C    = c_q;
  assign bus.Z    = z_q;
  assign bus.N    = n_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed spec vectors plus randomized
// ops against an arithmetic reference model; honours ALU_EXEC_MUL_EN.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN  = 1'b1;
  localparam int MUL_LAT = 33;
`else
  localparam bit MUL_EN  = 1'b0;
  localparam int MUL_LAT = 1;
`endif

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // Reference: plain 64-bit arithmetic, returns {y, O, C, Z, N}.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned ua, ub, p;
    longint          sa, sb, r;
    logic [31:0]     y;
    logic            o, c;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    y = 32'd0; o = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin y = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; r = sa + sb; o = (r > SMAX) || (r < SMIN); end
      3'd1: begin y = 32'(ua - ub); c = (ua >= ub); r = sa - sb; o = (r > SMAX) || (r < SMIN); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: begin
        if (MUL_EN) begin
          p = ua * ub;
          y = p[31:0];
          c = (p >> 32) != 64'd0;
          o = c;
        end
      end
      default: y = a;
    endcase
    return {y, o, c, (y == 32'd0), y[31]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request and return the cycle count from accept to done (0 = timeout).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_op_code = op; bus.data_a = a; bus.data_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.alu_op_code = 3'($urandom); bus.data_a = $urandom; bus.data_b = $urandom;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.y, bus.O, bus.C, bus.Z, bus.N} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h want=0", {bus.busy, bus.done, bus.y, bus.O, bus.C, bus.Z, bus.N});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [4] = '{3'd0, 3'd1, 3'd1, 3'd5};
    logic [31:0] as   [4] = '{32'h7FFF_FFFF, 32'd5, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] bs   [4] = '{32'd1, 32'd5, 32'd5, 32'd1};
    logic [35:0] want [4] = '{{32'h8000_0000, 4'b1001}, {32'd0, 4'b0110},
                              {32'hFFFF_FFFE, 4'b0001}, {32'd1, 4'b0000}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      total++;
      if (lat !== 1) begin
        bad++;
        $display("[TB] FAIL directed_latency[%0d] got=%0d want=1", i, lat);
      end
      total++;
      if ({bus.y, bus.O, bus.C, bus.Z, bus.N} !== want[i]) begin
        bad++;
        $display("[TB] FAIL directed_result[%0d] got=%h want=%h", i, {bus.y, bus.O, bus.C, bus.Z, bus.N}, want[i]);
      end
    end
  endtask

  task automatic test_op110();
    int lat;
`ifdef ALU_EXEC_MUL_EN
    run_op(3'd6, 32'd7, 32'd6, lat);
    total++;
    if (lat !== 33 || {bus.y, bus.O, bus.C, bus.Z, bus.N} !== {32'd42, 4'b0000}) begin
      bad++;
      $display("[TB] FAIL mul_7x6 lat=%0d got=%h want lat=33 res=%h", lat, {bus.y, bus.O, bus.C, bus.Z, bus.N}, {32'd42, 4'b0000});
    end
`else
    run_op(3'd6, 32'd3, 32'd4, lat);
    total++;
    if (lat !== 1 || {bus.y, bus.O, bus.C, bus.Z, bus.N} !== {32'd0, 4'b0010}) begin
      bad++;
      $display("[TB] FAIL op110_disabled lat=%0d got=%h want lat=1 res=%h", lat, {bus.y, bus.O, bus.C, bus.Z, bus.N}, {32'd0, 4'b0010});
    end
`endif
  endtask

  task automatic test_start_ignored();
    logic [31:0] prev_y;
    int          lat;
    int          extra;
    prev_y = bus.y;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_op_code = 3'd6; bus.data_a = 32'h0001_0000; bus.data_b = 32'h0001_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
      bus.start = 1'b0;
      if (i == 5) begin
        total++;
        if (bus.busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL busy_mid_mul got=%b want=1", bus.busy);
        end
        bus.start = 1'b1; bus.alu_op_code = 3'd0; bus.data_a = 32'd1; bus.data_b = 32'd1;
      end
      if (i == 10) begin
        total++;
        if (bus.y !== prev_y) begin
          bad++;
          $display("[TB] FAIL y_held got=%h want=%h", bus.y, prev_y);
        end
      end
    end
    total++;
    if (lat !== MUL_LAT) begin
      bad++;
      $display("[TB] FAIL busy_ignore_latency got=%0d want=%0d", lat, MUL_LAT);
    end
    total++;
    if ({bus.y, bus.O, bus.C, bus.Z, bus.N} !== model(3'd6, 32'h0001_0000, 32'h0001_0000)) begin
      bad++;
      $display("[TB] FAIL busy_ignore_result got=%h want=%h", {bus.y, bus.O, bus.C, bus.Z, bus.N},
               model(3'd6, 32'h0001_0000, 32'h0001_0000));
    end
    // Start presented in the done cycle must be dropped.
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_in_done_cycle got=%b want=1", bus.busy);
    end
    bus.start = 1'b1; bus.alu_op_code = 3'd7; bus.data_a = 32'h1234_5678; bus.data_b = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("[TB] FAIL start_in_done_cycle extra_done=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_op_code = MUL_EN ? 3'd6 : 3'd0; bus.data_a = 32'd7; bus.data_b = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.y, bus.O, bus.C, bus.Z, bus.N} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_op got=%h want=0", {bus.busy, bus.done, bus.y, bus.O, bus.C, bus.Z, bus.N});
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("[TB] FAIL no_done_after_reset got=%0d want=0", dones);
    end
    run_op(3'd0, 32'd2, 32'd2, lat);
    total++;
    if (lat !== 1 || {bus.y, bus.O, bus.C, bus.Z, bus.N} !== {32'd4, 4'b0000}) begin
      bad++;
      $display("[TB] FAIL add_after_reset lat=%0d got=%h want=%h", lat, {bus.y, bus.O, bus.C, bus.Z, bus.N}, {32'd4, 4'b0000});
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [35:0] want;
    int          lat;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      want = model(op, a, b);
      run_op(op, a, b, lat);
      total++;
      if (lat !== ((op == 3'd6) ? MUL_LAT : 1)) begin
        bad++;
        $display("[TB] FAIL random_latency[%0d] op=%0d got=%0d", i, op, lat);
      end
      total++;
      if ({bus.y, bus.O, bus.C, bus.Z, bus.N} !== want) begin
        bad++;
        $display("[TB] FAIL random_result[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b,
                 {bus.y, bus.O, bus.C, bus.Z, bus.N}, want);
      end
    end
  endtask

  // start held high every cycle: single-cycle ops are accepted every other cycle.
  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [35:0] want;
    bit          in_done;
    repeat (2) @(negedge clk);
    in_done = 1'b0;
    want = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      total++;
      if (bus.done !== in_done) begin
        bad++;
        $display("[TB] FAIL b2b_done[%0d] got=%b want=%b", k, bus.done, in_done);
      end
      if (in_done) begin
        total++;
        if ({bus.y, bus.O, bus.C, bus.Z, bus.N} !== want) begin
          bad++;
          $display("[TB] FAIL b2b_result[%0d] got=%h want=%h", k, {bus.y, bus.O, bus.C, bus.Z, bus.N}, want);
        end
      end
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6) op = 3'd7;
      a = pick_operand();
      b = pick_operand();
      bus.start = 1'b1; bus.alu_op_code = op; bus.data_a = a; bus.data_b = b;
      if (!in_done) want = model(op, a, b);
      in_done = !in_done;
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    bus.start = 1'b0; bus.alu_op_code = 3'd0; bus.data_a = '0; bus.data_b = '0;
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_op110();
    test_start_ignored();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
